// File: rtl/fp16_pkg.sv
// Shared FP16 format constants, operand classes and divider state encoding.
// The helper functions sort operands into classes and pick the special-case outcome of a divide.
package fp16_pkg;

   localparam int EXP_BIAS = 15;
   localparam int EXP_MAX  = 31;
   localparam int FRAC_W   = 10;
   localparam int QBITS    = 13;

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;
   localparam logic [15:0] NEG_INF = 16'hFC00;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_t;
   typedef enum logic [1:0] {IDLE, DIV, RND} div_state_t;

   // Denormals have no hidden bit in this datapath, so they are flushed to ZERO.
   function automatic op_class_t classify(input logic [15:0] x);
      op_class_t cls;
      if (x[14:10] == 5'd0)
         cls = ZERO;
      else if (x[14:10] != 5'(EXP_MAX))
         cls = NORM;
      else if (x[FRAC_W-1:0] == '0)
         cls = INF;
      else
         cls = NAN;
      return cls;
   endfunction

   // NORM means "use the arithmetic result"; any other class overrides it.
   function automatic op_class_t resolve_class(input op_class_t ca, input op_class_t cb);
      op_class_t res;
      if (ca == NAN || cb == NAN)
         res = NAN;
      else if (ca == INF && cb == INF)
         res = NAN;
      else if (ca == ZERO && cb == ZERO)
         res = NAN;
      else if (ca == INF)
         res = INF;
      else if (cb == INF)
         res = ZERO;
      else if (cb == ZERO)
         res = INF;
      else if (ca == ZERO)
         res = ZERO;
      else
         res = NORM;
      return res;
   endfunction

endpackage

// File: rtl/fp16_div_round.sv
// Normalise and round-to-nearest-even stage of the FP16 divider.
// Turns the raw 13-bit quotient, remainder flag and biased exponent into the final FP16 word.
module fp16_div_round
   import fp16_pkg::*;
(
   input  logic [QBITS-1:0] q,
   input  logic             rem_nz,
   input  logic signed [6:0] e,
   input  logic             sign,
   input  op_class_t        cls,
   output logic [15:0]      result
);

   logic [FRAC_W-1:0] frac_raw;
   logic [FRAC_W:0]   frac_sum;
   logic              guard;
   logic              sticky;
   logic              inc;
   logic signed [6:0] e_adj;
   logic signed [6:0] e_fin;

   always_comb begin
      frac_raw = '0;
      guard    = 1'b0;
      sticky   = 1'b0;
      e_adj    = e;
      // A quotient below 1.0 has its leading one at q[11] and costs one exponent step.
      if (q[QBITS-1]) begin
         frac_raw = q[QBITS-2:2];
         guard    = q[1];
         sticky   = q[0] | rem_nz;
      end else begin
         frac_raw = q[QBITS-3:1];
         guard    = q[0];
         sticky   = rem_nz;
         e_adj    = e - 7'sd1;
      end

      inc      = guard & (sticky | frac_raw[0]);
      frac_sum = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, inc};
      e_fin    = frac_sum[FRAC_W] ? e_adj + 7'sd1 : e_adj;

      case (cls)
         NAN:     result = QNAN;
         INF:     result = sign ? NEG_INF : POS_INF;
         ZERO:    result = {sign, 15'd0};
         default: begin
            if (e_fin >= 7'(EXP_MAX))
               result = sign ? NEG_INF : POS_INF;
            else if (e_fin <= 7'sd0)
               result = {sign, 15'd0};
            else
               result = {sign, e_fin[4:0], frac_sum[FRAC_W-1:0]};
         end
      endcase
   end

endmodule

// File: rtl/div_fp16.sv
// Iterative FP16 divider: restoring one-quotient-bit-per-cycle loop, then a round stage.
// Every operation takes the same 14 cycles from accepted start to the done pulse.
module div_fp16
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        nRST,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result,
   output logic        done,
   output logic        busy
);

   div_state_t        state_q, state_d;
   logic              sign_q, sign_d;
   logic signed [6:0] exp_q, exp_d;
   op_class_t         cls_q, cls_d;
   logic [FRAC_W:0]   mb_q, mb_d;
   logic [FRAC_W+1:0] rem_q, rem_d;
   logic [QBITS-1:0]  quo_q, quo_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       result_q, result_d;
   logic              done_q, done_d;

   logic [FRAC_W+1:0] rem_sub;
   logic              qbit;
   logic [15:0]       round_result;

   fp16_div_round u_round (
      .q      (quo_q),
      .rem_nz (|rem_q),
      .e      (exp_q),
      .sign   (sign_q),
      .cls    (cls_q),
      .result (round_result)
   );

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      cls_d    = cls_q;
      mb_d     = mb_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      rem_sub  = rem_q;
      qbit     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d  = a[15] ^ b[15];
               exp_d   = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]}) + 7'(EXP_BIAS);
               cls_d   = resolve_class(classify(a), classify(b));
               mb_d    = {1'b1, b[FRAC_W-1:0]};
               rem_d   = {2'b01, a[FRAC_W-1:0]};
               quo_d   = '0;
               cnt_d   = 4'(QBITS - 1);
               state_d = DIV;
            end
         end
         DIV: begin
            if (rem_q >= {1'b0, mb_q}) begin
               rem_sub = rem_q - {1'b0, mb_q};
               qbit    = 1'b1;
            end
            // rem_sub stays below mb, so the shift never drops a set bit.
            rem_d = rem_sub << 1;
            quo_d = {quo_q[QBITS-2:0], qbit};
            if (cnt_q == 4'd0)
               state_d = RND;
            else
               cnt_d = cnt_q - 4'd1;
         end
         RND: begin
            result_d = round_result;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         cls_q    <= ZERO;
         mb_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         cls_q    <= cls_d;
         mb_q     <= mb_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: doc/div_fp16.md
Name: div_fp16

Overview:
- Iterative FP16 (1/5/10, bias 15) divider that computes result = a / b.
- Shares the start/done operand handshake used by the tensor core's FP16 arithmetic units, so a scheduler can issue multiplies and divides the same way.
- Mantissa quotient uses a restoring, one-bit-per-cycle datapath, followed by a normalise/round stage.
- Latency is fixed regardless of operand values.

Parameters:
- None. Format constants live in the shared package.

Ports:
- clk     in   1   rising-edge clock
- nRST    in   1   asynchronous active-low reset
- start   in   1   operand valid; sampled only when busy=0
- a       in   16  FP16 dividend
- b       in   16  FP16 divisor
- result  out  16  FP16 quotient; holds until the next accepted operation completes
- done    out  1   single-cycle pulse; result is valid in the same cycle
- busy    out  1   high while an operation is in flight

Behaviour:
- Reset (async, nRST=0): state IDLE, result=0, done=0, busy=0, all internal registers cleared.
  - Reset mid-operation aborts the operation. No done pulse is produced for it.
- States:
  - IDLE: if start=1, latch a and b, classify the operands, load ma={1,a[9:0]}, mb={1,b[9:0]}, rem=ma, cnt=12. Go to DIV.
  - DIV: each cycle, if rem>=mb then q bit=1 and rem-=mb, else q bit=0. Then rem<<=1 and cnt--. Bits fill q[12] down to q[0]. When cnt reaches 0 after the 13th bit, go to RND.
  - RND: normalise and round (see below), register result, pulse done. Go to IDLE.
- Latency: start sampled at edge N, so done=1 and result is valid in the cycle after edge N+14.
  - Special-case operands take the same 14-cycle path; the arithmetic result is overridden in RND.
- busy=1 from edge N through edge N+13. busy=0 in the done cycle.
- start while busy=1 is ignored. start in the done cycle is accepted, giving back-to-back operation.
- Arithmetic:
  - Sign is a[15]^b[15].
  - Exponent is e = a_exp - b_exp + 15, held in a signed 7-bit value.
  - If q[12]=1: significand q[12:2], guard q[1], sticky q[0] | (rem!=0).
  - If q[12]=0: significand q[11:1], guard q[0], sticky (rem!=0); e -= 1.
  - Round to nearest even: increment when guard & (sticky | lsb). If the increment carries out of the significand, set significand=1.0 and e += 1.
  - If final e >= 31, result = signed infinity (exp 11111, frac 0).
  - If final e <= 0, result = signed zero. There is no denormal output.
- Special cases, in priority order:
  - Either operand NaN (exp=31, frac!=0) → 0x7E00.
  - inf/inf → 0x7E00.
  - zero/zero → 0x7E00.
  - inf/x → signed infinity.
  - x/inf → signed zero.
  - x/zero → signed infinity.
  - zero/x → signed zero.
- Denormal inputs (exp=0) are treated as zero.

Decomposition:
- Package fp16_pkg contains:
  - EXP_BIAS=15, EXP_MAX=31, FRAC_W=10, QBITS=13
  - QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00
  - operand-class enum: ZERO, NORM, INF, NAN
  - divider state enum: IDLE, DIV, RND
- One combinational sub-module, fp16_div_round, is natural.
  - Inputs: q, rem_nz, e, sign, special class.
  - Output: final 16-bit result.
  - It can be unit-tested on its own.

Test Plan:
- a=0x4600 (6.0), b=0x4000 (2.0), start at edge N → done pulses one cycle after edge N+14, result=0x4200; busy=1 for 14 cycles; done is a one-cycle pulse.
- a=0x3C00, b=0x4200 (1/3) → result=0x3555 (guard=0, no round-up); a=0xBC00, b=0x4200 → result=0xB555.
- Specials:
  - a=0xBC00, b=0x0000 → 0xFC00
  - a=0x0000, b=0x0000 → 0x7E00
  - a=0x7C00, b=0x4000 → 0x7C00
  - a=0x7E01, b=0x3C00 → 0x7E00
  - In every case latency is still 14.
- Range limits:
  - a=0x7BFF, b=0x3800 → overflow → 0x7C00
  - a=0x0400, b=0x4000 → underflow → 0x0000
- Handshake:
  - Pulse start again at edges N+3 and N+7 with different operands → ignored; first result unchanged.
  - Assert start with new operands in the done cycle → accepted; second done arrives exactly 14 cycles later.
- Reset mid-operation: drop nRST at edge N+6 → result=0, busy=0, done=0 immediately; no done pulse follows. After release, a fresh start completes normally.
